// File: rtl/tmr_scrub_pkg.sv
// Shared types and constants for the triplicated scrubbed register bank.
package tmr_scrub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIX  = 2'd1,
      DONE = 2'd2
   } scrub_state_t;

   localparam logic [1:0] COPY_A    = 2'd0;
   localparam logic [1:0] COPY_B    = 2'd1;
   localparam logic [1:0] COPY_C    = 2'd2;
   localparam logic [1:0] COPY_NONE = 2'd3;

endpackage

// File: rtl/maj3_vote.sv
// Purely combinational bitwise 2-of-3 majority voter.
module maj3_vote #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] y
);

   assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_scrub_reg.sv
// Triplicated register with majority vote, disagreement detection, an
// autonomous scrub FSM that repairs corrupted copies, and fault injection.
module tmr_scrub_reg
   import tmr_scrub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             inj_en,
   input  logic [1:0]       inj_copy,
   input  logic [WIDTH-1:0] inj_mask,
   input  logic             scrub_req,
   output logic [WIDTH-1:0] data_out,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt_a,
   output logic [CNT_W-1:0] err_cnt_b,
   output logic [CNT_W-1:0] err_cnt_c,
   output logic             busy,
   output logic             scrub_done
);

   logic [WIDTH-1:0] copy_a_q, copy_a_d;
   logic [WIDTH-1:0] copy_b_q, copy_b_d;
   logic [WIDTH-1:0] copy_c_q, copy_c_d;
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
   logic [CNT_W-1:0] cnt_c_q, cnt_c_d;
   scrub_state_t     state_q, state_d;
   logic [WIDTH-1:0] vote;
   logic             dis_a, dis_b, dis_c;

   maj3_vote #(.WIDTH(WIDTH)) u_vote (
      .a (copy_a_q),
      .b (copy_b_q),
      .c (copy_c_q),
      .y (vote)
   );

   assign dis_a      = (copy_a_q != vote);
   assign dis_b      = (copy_b_q != vote);
   assign dis_c      = (copy_c_q != vote);
   assign data_out   = vote;
   assign mismatch   = dis_a | dis_b | dis_c;
   assign busy       = (state_q != IDLE);
   assign scrub_done = (state_q == DONE);
   assign err_cnt_a  = cnt_a_q;
   assign err_cnt_b  = cnt_b_q;
   assign err_cnt_c  = cnt_c_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      copy_a_d = copy_a_q;
      copy_b_d = copy_b_q;
      copy_c_d = copy_c_q;
      cnt_a_d  = cnt_a_q;
      cnt_b_d  = cnt_b_q;
      cnt_c_d  = cnt_c_q;
      state_d  = state_q;

      if (wr_en) begin
         copy_a_d = wr_data;
         copy_b_d = wr_data;
         copy_c_d = wr_data;
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE: if (mismatch || scrub_req) state_d = FIX;
            FIX: begin
               state_d = DONE;
               if (dis_a) begin copy_a_d = vote; cnt_a_d = sat_inc(cnt_a_q); end
               if (dis_b) begin copy_b_d = vote; cnt_b_d = sat_inc(cnt_b_q); end
               if (dis_c) begin copy_c_d = vote; cnt_c_d = sat_inc(cnt_c_q); end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // Injection lands on top of the write/repair result, so it can undo a repair.
      if (inj_en) begin
         case (inj_copy)
            COPY_A:  copy_a_d = copy_a_d ^ inj_mask;
            COPY_B:  copy_b_d = copy_b_d ^ inj_mask;
            COPY_C:  copy_c_d = copy_c_d ^ inj_mask;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         copy_a_q <= '0;
         copy_b_q <= '0;
         copy_c_q <= '0;
         cnt_a_q  <= '0;
         cnt_b_q  <= '0;
         cnt_c_q  <= '0;
         state_q  <= IDLE;
      end else begin
         copy_a_q <= copy_a_d;
         copy_b_q <= copy_b_d;
         copy_c_q <= copy_c_d;
         cnt_a_q  <= cnt_a_d;
         cnt_b_q  <= cnt_b_d;
         cnt_c_q  <= cnt_c_d;
         state_q  <= state_d;
      end
   end

endmodule
